gray_counter: RTL and testbench

//  Registered up/down Gray-code counter; sits directly upstream of gray2bin and

---
 rtl/gray_counter_pkg.sv | 6 +
 rtl/bin2gray_comb.sv | 11 +
 rtl/gray_counter.sv | 46 ++++
 tb/tb_gray_counter.sv | 85 ++++++++
 4 files changed

// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg: shared binary-to-Gray helper
package gray_counter_pkg;
  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/bin2gray_comb.sv
// bin2gray_comb: combinational binary-to-Gray encoder
module bin2gray_comb
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);
  assign g = WIDTH'(bin2gray(64'(b)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray counter with load, saturate/wrap and wrap pulse
module gray_counter #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic SAT = SATURATE != 0;
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, step;
  logic wrap_q, wrap_d, at_end;
  always_comb begin
    at_end = up ? bin_q == MAX : bin_q == '0;
    step   = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
    bin_d  = load ? load_bin : !en ? bin_q : (at_end && SAT) ? bin_q : step;
    wrap_d = !load && en && at_end && !SAT;
  end
  // Gray image is encoded from the next state so the output is a clean register
  bin2gray_comb #(.WIDTH(WIDTH)) u_enc (.b(bin_d), .g(gray_d));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end
  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign at_max   = bin_q == MAX;
  assign at_min   = bin_q == '0;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed + random checks of wrapping and saturating counters against a count model
module tb_gray_counter;
  logic clk = 1'b0;
  logic rst_n, en, up, load;
  logic [3:0] load_bin;
  logic [3:0] gray_o[2], bin_o[2];
  logic wrap_o[2], amax_o[2], amin_o[2];
  int vectors = 0, miscompares = 0;
  int m_bin[2], m_wrap[2], gseq[16];
  always #5 clk = ~clk;
  gray_counter #(.WIDTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray_out(gray_o[0]), .bin_out(bin_o[0]), .wrap(wrap_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0]));
  gray_counter #(.WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .gray_out(gray_o[1]), .bin_out(bin_o[1]), .wrap(wrap_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1]));
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic step(input logic rn, input logic e, input logic u, input logic l, input logic [3:0] lb);
    logic [3:0] pg[2], dec;
    int pb[2];
    rst_n = rn; en = e; up = u; load = l; load_bin = lb;
    for (int s = 0; s < 2; s++) begin
      pg[s] = gray_o[s];
      pb[s] = m_bin[s];
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      m_wrap[s] = 0;
      if (!rn) m_bin[s] = 0;
      else if (l) m_bin[s] = int'(lb);
      else if (e && u) begin
        if (m_bin[s] < 15) m_bin[s]++;
        else if (s == 0) begin m_bin[s] = 0; m_wrap[s] = 1; end
      end else if (e) begin
        if (m_bin[s] > 0) m_bin[s]--;
        else if (s == 0) begin m_bin[s] = 15; m_wrap[s] = 1; end
      end
      chk($sformatf("bin[%0d]", s), bin_o[s], 4'(m_bin[s]));
      chk($sformatf("gray[%0d]", s), gray_o[s], 4'(gseq[m_bin[s]]));
      chk($sformatf("wrap[%0d]", s), {3'b0, wrap_o[s]}, 4'(m_wrap[s]));
      chk($sformatf("at_max[%0d]", s), {3'b0, amax_o[s]}, {3'b0, m_bin[s] == 15});
      chk($sformatf("at_min[%0d]", s), {3'b0, amin_o[s]}, {3'b0, m_bin[s] == 0});
      for (int i = 0; i < 4; i++) dec[i] = ^(gray_o[s] >> i);
      chk($sformatf("gray2bin[%0d]", s), dec, 4'(m_bin[s]));
      if (rn && !l && e)
        chk($sformatf("hamming[%0d]", s), 4'($countones(pg[s] ^ gray_o[s])), {3'b0, pb[s] != m_bin[s]});
    end
  endtask
  initial begin
    gseq[0] = 0;
    for (int n = 1; n < 16; n *= 2)
      for (int k = 0; k < n; k++) gseq[2*n-1-k] = gseq[k] + n;
    m_bin = '{0, 0};
    m_wrap = '{0, 0};
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_bin = 4'hA;
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    repeat (16) step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'hE);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'hF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'h5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 31) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
           $urandom_range(0, 15) == 0, 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
